pmod_adc_spi_responder: RTL

SPI responder that emulates the PmodMIC3 ADC on a PMOD header so that SPI readers in the design can be tested on the board or in loopback without the microphone. A frame is started by the reader pulling CS_N low. The block then serves 16 bits, MSB first: four leading zeros followed by a 12-bit sample taken from a one-entry holding buffer. SCLK and CS_N are sampled in the `sysclk` domain, and the block sits between a sample source (tone generator, pattern ROM) and the PMOD IOBUFs.

---
 rtl/pmod_adc_spi_responder_pkg.sv | 15 +
 rtl/pmod_adc_spi_responder_if.sv | 12 +
 rtl/pmod_adc_spi_responder_sync.sv | 30 +++
 rtl/pmod_adc_spi_responder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pmod_adc_spi_responder_pkg.sv
// Shared types and constants for the PmodMIC3 ADC emulator.
// The frame layout is four leading zeros followed by a 12-bit sample, MSB first.
package pmod_adc_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_TAIL} spi_rsp_state_t;

    localparam int FRAME_BITS  = 16;
    localparam int SAMPLE_BITS = 12;
    localparam int LEAD_ZEROS  = 4;

    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [SAMPLE_BITS-1:0] sample);
        return {{LEAD_ZEROS{1'b0}}, sample};
    endfunction

endpackage

// File: rtl/pmod_adc_spi_responder_if.sv
// Valid/ready sample stream feeding the responder's one-entry holding buffer.
interface pmod_adc_spi_responder_if;
    import pmod_adc_pkg::*;

    logic [SAMPLE_BITS-1:0] s_data;
    logic                   s_valid;
    logic                   s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/pmod_adc_spi_responder_sync.sv
// Synchronizer chain plus history flop for one asynchronous pin, with registered edge pulses.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   hist;

    // Chain resets to 0 so a pin already low at reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            hist  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
            hist  <= chain[SYNC_STAGES-1];
            rise  <= chain[SYNC_STAGES-1] & ~hist;
            fall  <= ~chain[SYNC_STAGES-1] & hist;
        end
    end

endmodule

// File: rtl/pmod_adc_spi_responder.sv
// SPI responder emulating the PmodMIC3 ADC: serves {4'b0, sample} MSB first on each CS_N frame,
// shifting on SCLK falling edges, with all SPI pins sampled in the sysclk domain.
module pmod_adc_spi_responder
    import pmod_adc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                      sysclk,
    input  logic                      sysrst_n,
    input  logic                      spi_sclk,
    input  logic                      spi_cs_n,
    output logic                      spi_sdata,
    output logic                      spi_sdata_oe,
    pmod_adc_spi_responder_if.slave   smp,
    output logic                      frame_done,
    output logic                      frame_abort,
    output logic                      underrun
);

    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(sysclk), .rst_n(sysrst_n), .pin(spi_sclk), .rise(sclk_rise), .fall(sclk_fall)
    );

    // CS_N is active-low: its falling edge opens a frame, its rising edge closes it.
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(sysclk), .rst_n(sysrst_n), .pin(spi_cs_n), .rise(cs_rise), .fall(cs_fall)
    );

    spi_rsp_state_t         state_q, state_n;
    logic [FRAME_BITS-1:0]  shreg_q, shreg_n;
    logic [4:0]             rise_cnt_q, rise_cnt_n;
    logic [SAMPLE_BITS-1:0] last_sample_q, last_sample_n;
    logic [SAMPLE_BITS-1:0] hold_data_q;
    logic                   hold_full_q;
    logic                   done_n, abort_n, underrun_n;
    logic                   load, transfer;

    assign load        = (state_q == ST_IDLE) & cs_fall;
    assign smp.s_ready = ~hold_full_q | load;
    assign transfer    = smp.s_valid & smp.s_ready;

    always_comb begin
        state_n       = state_q;
        shreg_n       = shreg_q;
        rise_cnt_n    = rise_cnt_q;
        last_sample_n = last_sample_q;
        done_n        = 1'b0;
        abort_n       = 1'b0;
        underrun_n    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_n    = ST_SHIFT;
                    rise_cnt_n = '0;
                    if (hold_full_q) begin
                        shreg_n       = frame_word(hold_data_q);
                        last_sample_n = hold_data_q;
                    end else begin
                        shreg_n    = frame_word(last_sample_q);
                        underrun_n = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                // CS rising takes priority over any SCLK edge seen in the same cycle.
                if (cs_rise) begin
                    state_n = ST_IDLE;
                    done_n  = (rise_cnt_q == CNT_FULL);
                    abort_n = (rise_cnt_q != CNT_FULL);
                end else if (sclk_rise) begin
                    if (rise_cnt_q != CNT_FULL) rise_cnt_n = rise_cnt_q + 5'd1;
                end else if (sclk_fall) begin
                    if (rise_cnt_q == CNT_FULL)  state_n = ST_TAIL;
                    else if (rise_cnt_q != '0)   shreg_n = {shreg_q[FRAME_BITS-2:0], 1'b0};
                end
            end
            ST_TAIL: begin
                if (cs_rise) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            rise_cnt_q    <= '0;
            last_sample_q <= '0;
            hold_full_q   <= 1'b0;
            spi_sdata     <= 1'b0;
            spi_sdata_oe  <= 1'b0;
            frame_done    <= 1'b0;
            frame_abort   <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            state_q       <= state_n;
            shreg_q       <= shreg_n;
            rise_cnt_q    <= rise_cnt_n;
            last_sample_q <= last_sample_n;
            if (transfer)  hold_full_q <= 1'b1;
            else if (load) hold_full_q <= 1'b0;
            spi_sdata     <= (state_n == ST_SHIFT) & shreg_n[FRAME_BITS-1];
            spi_sdata_oe  <= (state_n == ST_SHIFT);
            frame_done    <= done_n;
            frame_abort   <= abort_n;
            underrun      <= underrun_n;
        end
    end

    // The payload is only meaningful while hold_full is set, so it needs no reset.
    always_ff @(posedge sysclk) begin
        if (transfer) hold_data_q <= smp.s_data;
    end

endmodule
